// File: rtl/cluster_ctrl_pkg.sv
// Shared types for the PE cluster sequencing controller: FSM state encoding
// and the router direction codes understood by the GLB-to-cluster routers.
package cluster_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        WGHT_REQ   = 4'd1,
        WGHT_LOAD  = 4'd2,
        ACT_REQ    = 4'd3,
        ACT_LOAD   = 4'd4,
        COMP_START = 4'd5,
        COMP_WAIT  = 4'd6,
        PSUM_WB    = 4'd7,
        DONE       = 4'd8
    } state_t;

    typedef enum logic [3:0] {
        ALL        = 4'd0,
        NORTH      = 4'd1,
        SOUTH      = 4'd2,
        WEST       = 4'd3,
        EAST       = 4'd4,
        NORTHSOUTH = 4'd5,
        NORTHWEST  = 4'd6,
        NORTHEAST  = 4'd7,
        SOUTHWEST  = 4'd8,
        SOUTHEAST  = 4'd9,
        WESTEAST   = 4'd10
    } router_dir_t;

    // Width of the free-running busy cycle counter.
    localparam int CYCLE_CNT_W = 32;

endpackage

// File: rtl/cluster_seq_ctrl.sv
// Cluster sequencing controller: streams the filter and activation tiles
// from the GLB into the PE cluster through the routers, launches NUM_ITER
// compute passes and writes each pass's column psums back to the GLB.
module cluster_seq_ctrl
    import cluster_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 10,
    parameter int KERNEL_SIZE = 3,
    parameter int ACT_SIZE    = 5,
    parameter int X_DIM       = 3,
    parameter int NUM_ITER    = 3,
    parameter int PSUM_BASE   = 500
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start_i,
    output logic                              read_req_wght_o,
    output logic [ADDR_WIDTH-1:0]             r_addr_wght_o,
    output logic                              read_req_iact_o,
    output logic [ADDR_WIDTH-1:0]             r_addr_iact_o,
    output logic [3:0]                        router_mode_wght_o,
    output logic [3:0]                        router_mode_iact_o,
    output logic                              west_enable_wght_o,
    output logic                              west_enable_iact_o,
    output logic                              load_en_wght_o,
    output logic                              load_en_act_o,
    output logic                              pe_start_o,
    input  logic                              compute_done_i,
    input  logic [X_DIM-1:0][DATA_WIDTH-1:0]  pe_out_i,
    output logic                              psum_write_en_o,
    output logic [ADDR_WIDTH-1:0]             psum_w_addr_o,
    output logic [DATA_WIDTH-1:0]             psum_w_data_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic [CYCLE_CNT_W-1:0]            cycle_cnt_o
);

    localparam int WGHT_LEN = KERNEL_SIZE * KERNEL_SIZE;
    localparam int ACT_LEN  = ACT_SIZE * ACT_SIZE;
    localparam int STEP_W   = 16;
    localparam int ITER_W   = 8;
    localparam int SEL_W    = (X_DIM > 1) ? $clog2(X_DIM) : 1;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [STEP_W-1:0]        r_step;      // load address / writeback index
    logic [ITER_W-1:0]        r_iter;      // current compute pass
    logic [CYCLE_CNT_W-1:0]   r_cycle_cnt;

    logic                     w_wght_last;
    logic                     w_act_last;
    logic                     w_wb_last;
    logic                     w_more_iter;
    logic [SEL_W-1:0]         w_sel;
    logic [ADDR_WIDTH-1:0]    w_psum_addr;

    assign w_wght_last = (r_step == STEP_W'(WGHT_LEN));
    assign w_act_last  = (r_step == STEP_W'(ACT_LEN));
    assign w_wb_last   = (r_step == STEP_W'(X_DIM - 1));
    assign w_more_iter = (r_iter < ITER_W'(NUM_ITER - 1));

    // Columns are written highest-index first.
    assign w_sel       = SEL_W'(X_DIM - 1) - SEL_W'(r_step);
    // Psum address wraps within the GLB address space.
    assign w_psum_addr = ADDR_WIDTH'(PSUM_BASE + int'(r_iter) * X_DIM + int'(r_step));

    assign cycle_cnt_o = r_cycle_cnt;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Step counter: load address during the load phases, column index during writeback.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_step <= 16'd0;
        end else begin
            case (r_state)
                WGHT_REQ:  r_step <= 16'd1;
                WGHT_LOAD: r_step <= w_wght_last ? 16'd0 : (r_step + 16'd1);
                ACT_REQ:   r_step <= 16'd1;
                ACT_LOAD:  r_step <= w_act_last ? 16'd0 : (r_step + 16'd1);
                PSUM_WB:   r_step <= w_wb_last ? 16'd0 : (r_step + 16'd1);
                default:   r_step <= 16'd0;
            endcase
        end
    end

    // Compute pass counter: cleared by a new job, advanced after each writeback.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_iter <= 8'd0;
        end else if ((r_state == IDLE) && start_i) begin
            r_iter <= 8'd0;
        end else if ((r_state == PSUM_WB) && w_wb_last && w_more_iter) begin
            r_iter <= r_iter + 8'd1;
        end else begin
            r_iter <= r_iter;
        end
    end

    // Busy cycle counter: cleared at job start, saturating, frozen in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle_cnt <= 32'd0;
        end else if ((r_state == IDLE) && start_i) begin
            r_cycle_cnt <= 32'd0;
        end else if ((r_state != IDLE) && (r_cycle_cnt != 32'hFFFF_FFFF)) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end else begin
            r_cycle_cnt <= r_cycle_cnt;
        end
    end

    // Next-state and output decode; all outputs depend on registered state,
    // except the psum data, which passes pe_out_i straight through.
    always_comb begin
        w_state_next       = r_state;
        read_req_wght_o    = 1'b0;
        r_addr_wght_o      = '0;
        read_req_iact_o    = 1'b0;
        r_addr_iact_o      = '0;
        router_mode_wght_o = ALL;
        router_mode_iact_o = ALL;
        west_enable_wght_o = 1'b0;
        west_enable_iact_o = 1'b0;
        load_en_wght_o     = 1'b0;
        load_en_act_o      = 1'b0;
        pe_start_o         = 1'b0;
        psum_write_en_o    = 1'b0;
        psum_w_addr_o      = '0;
        psum_w_data_o      = '0;
        busy_o             = (r_state != IDLE);
        done_o             = 1'b0;

        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state_next = WGHT_REQ;
                end else begin
                    w_state_next = IDLE;
                end
            end
            WGHT_REQ: begin
                read_req_wght_o = 1'b1;
                r_addr_wght_o   = ADDR_WIDTH'(r_step);
                w_state_next    = WGHT_LOAD;
            end
            WGHT_LOAD: begin
                read_req_wght_o    = 1'b1;
                r_addr_wght_o      = ADDR_WIDTH'(r_step);
                west_enable_wght_o = 1'b1;
                router_mode_wght_o = WEST;
                load_en_wght_o     = (r_step == 16'd1);
                if (w_wght_last) begin
                    w_state_next = ACT_REQ;
                end else begin
                    w_state_next = WGHT_LOAD;
                end
            end
            ACT_REQ: begin
                read_req_iact_o = 1'b1;
                r_addr_iact_o   = ADDR_WIDTH'(r_step);
                w_state_next    = ACT_LOAD;
            end
            ACT_LOAD: begin
                read_req_iact_o    = 1'b1;
                r_addr_iact_o      = ADDR_WIDTH'(r_step);
                west_enable_iact_o = 1'b1;
                router_mode_iact_o = WEST;
                load_en_act_o      = (r_step == 16'd1);
                if (w_act_last) begin
                    w_state_next = COMP_START;
                end else begin
                    w_state_next = ACT_LOAD;
                end
            end
            COMP_START: begin
                pe_start_o   = 1'b1;
                w_state_next = COMP_WAIT;
            end
            COMP_WAIT: begin
                if (compute_done_i) begin
                    w_state_next = PSUM_WB;
                end else begin
                    w_state_next = COMP_WAIT;
                end
            end
            PSUM_WB: begin
                psum_write_en_o = 1'b1;
                psum_w_addr_o   = w_psum_addr;
                psum_w_data_o   = pe_out_i[w_sel];
                if (!w_wb_last) begin
                    w_state_next = PSUM_WB;
                end else if (w_more_iter) begin
                    w_state_next = COMP_START;
                end else begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done_o       = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cluster_seq_ctrl.sv
// Scoreboard bench for cluster_seq_ctrl: the driver queues the expected GLB
// reads, psum writes, compute starts and done pulses for each job; a negedge
// monitor pops and compares whenever the DUT presents one of them.
module tb_cluster_seq_ctrl;

    logic              clk = 1'b0;
    logic              reset;
    logic              start_i;
    logic              read_req_wght_o;
    logic [9:0]        r_addr_wght_o;
    logic              read_req_iact_o;
    logic [9:0]        r_addr_iact_o;
    logic [3:0]        router_mode_wght_o;
    logic [3:0]        router_mode_iact_o;
    logic              west_enable_wght_o;
    logic              west_enable_iact_o;
    logic              load_en_wght_o;
    logic              load_en_act_o;
    logic              pe_start_o;
    logic              compute_done_i;
    logic [2:0][15:0]  pe_out;
    logic              psum_write_en_o;
    logic [9:0]        psum_w_addr_o;
    logic [15:0]       psum_w_data_o;
    logic              busy_o;
    logic              done_o;
    logic [31:0]       cycle_cnt_o;

    int checks = 0;
    int errors = 0;

    // {load_en, west_enable, router_mode, addr}
    logic [15:0] q_wght[$];
    logic [15:0] q_iact[$];
    // {addr, data}
    logic [25:0] q_psum[$];
    int          q_start[$];
    int          q_done[$];

    always #5 clk = ~clk;

    cluster_seq_ctrl dut (
        .clk                (clk),
        .reset              (reset),
        .start_i            (start_i),
        .read_req_wght_o    (read_req_wght_o),
        .r_addr_wght_o      (r_addr_wght_o),
        .read_req_iact_o    (read_req_iact_o),
        .r_addr_iact_o      (r_addr_iact_o),
        .router_mode_wght_o (router_mode_wght_o),
        .router_mode_iact_o (router_mode_iact_o),
        .west_enable_wght_o (west_enable_wght_o),
        .west_enable_iact_o (west_enable_iact_o),
        .load_en_wght_o     (load_en_wght_o),
        .load_en_act_o      (load_en_act_o),
        .pe_start_o         (pe_start_o),
        .compute_done_i     (compute_done_i),
        .pe_out_i           (pe_out),
        .psum_write_en_o    (psum_write_en_o),
        .psum_w_addr_o      (psum_w_addr_o),
        .psum_w_data_o      (psum_w_data_o),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .cycle_cnt_o        (cycle_cnt_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: DUT output with empty scoreboard at %0t", name, $time);
    endtask

    function automatic logic [15:0] rd_entry(input logic le, input logic we,
                                             input logic [3:0] mode, input int addr);
        return {le, we, mode, 10'(addr)};
    endfunction

    // Expected transactions of one complete job (passes use pe_out 7/8/9 + 16*pass).
    task automatic push_job();
        q_wght.push_back(rd_entry(1'b0, 1'b0, 4'd0, 0));
        for (int k = 1; k <= 9; k++) q_wght.push_back(rd_entry(k == 1, 1'b1, 4'd3, k));
        q_iact.push_back(rd_entry(1'b0, 1'b0, 4'd0, 0));
        for (int k = 1; k <= 25; k++) q_iact.push_back(rd_entry(k == 1, 1'b1, 4'd3, k));
        for (int p = 0; p < 3; p++) begin
            q_start.push_back(p);
            for (int i = 0; i < 3; i++)
                q_psum.push_back({10'(500 + 3 * p + i), 16'(9 - i + 16 * p)});
        end
        q_done.push_back(1);
    endtask

    // Monitor: compare every presented transaction against the scoreboard.
    always @(negedge clk) begin
        logic [15:0] ew;
        logic [25:0] ep;
        int          es;
        if (!reset) begin
            if (read_req_wght_o) begin
                if (q_wght.size() == 0) unexpected("wght_rd");
                else begin
                    ew = q_wght.pop_front();
                    check("wght_rd", {16'd0, load_en_wght_o, west_enable_wght_o,
                                      router_mode_wght_o, r_addr_wght_o}, {16'd0, ew});
                end
            end else begin
                check("wght_idle", {28'd0, load_en_wght_o, west_enable_wght_o,
                                    router_mode_wght_o[1:0]}, 32'd0);
            end
            if (read_req_iact_o) begin
                if (q_iact.size() == 0) unexpected("iact_rd");
                else begin
                    ew = q_iact.pop_front();
                    check("iact_rd", {16'd0, load_en_act_o, west_enable_iact_o,
                                      router_mode_iact_o, r_addr_iact_o}, {16'd0, ew});
                end
            end else begin
                check("iact_idle", {28'd0, load_en_act_o, west_enable_iact_o,
                                    router_mode_iact_o[1:0]}, 32'd0);
            end
            if (psum_write_en_o) begin
                if (q_psum.size() == 0) unexpected("psum_wr");
                else begin
                    ep = q_psum.pop_front();
                    check("psum_wr", {6'd0, psum_w_addr_o, psum_w_data_o}, {6'd0, ep});
                end
            end
            if (pe_start_o) begin
                if (q_start.size() == 0) unexpected("pe_start");
                else es = q_start.pop_front();
            end
            if (done_o) begin
                if (q_done.size() == 0) unexpected("done");
                else es = q_done.pop_front();
            end
        end
    end

    task automatic wait_pe_start(input int limit);
        bit ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (pe_start_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL pe_start_timeout: no pe_start_o within %0d cycles", limit);
        end
    endtask

    task automatic wait_done(input int limit);
        bit ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (done_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done_o within %0d cycles", limit);
        end
    endtask

    // One complete job; waits[p]==0 raises compute_done_i before COMP_WAIT is entered.
    task automatic run_job(input int w0, input int w1, input int w2,
                           input bit inject_start, input int exp_cnt);
        int waits[3];
        waits[0] = w0;
        waits[1] = w1;
        waits[2] = w2;
        push_job();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int p = 0; p < 3; p++) begin
            wait_pe_start(200);
            pe_out[0] = 16'(7 + 16 * p);
            pe_out[1] = 16'(8 + 16 * p);
            pe_out[2] = 16'(9 + 16 * p);
            if (waits[p] == 0) begin
                compute_done_i = 1'b1;
                @(posedge clk);
                @(posedge clk);
                #1 compute_done_i = 1'b0;
            end else begin
                for (int c = 0; c < waits[p]; c++) begin
                    @(posedge clk);
                    #1 start_i = inject_start && (c == 3);
                end
                compute_done_i = 1'b1;
                @(posedge clk);
                #1 compute_done_i = 1'b0;
                start_i = 1'b0;
            end
        end
        wait_done(50);
        @(negedge clk);
        check("busy_after_job", {31'd0, busy_o}, 32'd0);
        check("done_after_job", {31'd0, done_o}, 32'd0);
        check("cycle_cnt_job", cycle_cnt_o, 32'(exp_cnt));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        check({tag, "_cnt"}, cycle_cnt_o, 32'd0);
        check({tag, "_wght"}, {16'd0, read_req_wght_o, r_addr_wght_o, router_mode_wght_o,
                               west_enable_wght_o}, 32'd0);
        check({tag, "_iact"}, {16'd0, read_req_iact_o, r_addr_iact_o, router_mode_iact_o,
                               west_enable_iact_o}, 32'd0);
        check({tag, "_strobes"}, {28'd0, load_en_wght_o, load_en_act_o, pe_start_o, done_o},
              32'd0);
        check({tag, "_psum"}, {5'd0, psum_write_en_o, psum_w_addr_o, psum_w_data_o}, 32'd0);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed job sequence.
    initial begin
        int n;
        bit ok;
        reset          = 1'b0;
        start_i        = 1'b0;
        compute_done_i = 1'b0;
        pe_out         = '0;
        #1 reset = 1'b1;
        #2 check_all_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Full job with 20-cycle computes and a stray start_i during COMP_WAIT.
        run_job(20, 20, 20, 1'b1, 109);
        repeat (3) @(negedge clk);

        // Job abandoned by reset in the middle of ACT_LOAD.
        push_job();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n  = 0;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (read_req_iact_o) n++;
            if (n == 10) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL act_load_timeout: only %0d iact reads seen", n);
        end
        #2 reset = 1'b1;
        #1 check_all_zero("midjob_reset");
        q_wght.delete();
        q_iact.delete();
        q_psum.delete();
        q_start.delete();
        q_done.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Fresh job after the abort, including an early compute_done_i.
        run_job(0, 5, 20, 1'b0, 75);
        repeat (3) @(negedge clk);

        check("left_wght", 32'(q_wght.size()), 32'd0);
        check("left_iact", 32'(q_iact.size()), 32'd0);
        check("left_psum", 32'(q_psum.size()), 32'd0);
        check("left_start", 32'(q_start.size()), 32'd0);
        check("left_done", 32'(q_done.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
